// File: rtl/x_300_mod_47_loader.sv
// Word-serial loader for the 300-bit mod-47 residue core. Words are assembled LS first,
// and the registered residue is held until the consumer takes it.
//   state | meaning
//   LOAD  | accepting words into the operand register
//   CALC  | operand complete, capture the core residue
//   HOLD  | residue valid, waiting for out_ready

module x_300_mod_47 (
  input  logic [299:0] x,
  output logic [5:0]   r
);
  // 2 has order 23 modulo 47, so 23-bit chunks all carry weight 1 and can simply be summed.
  logic [321:0] x_pad;
  logic [26:0]  acc;
  logic [23:0]  fold;

  always_comb begin
    x_pad = {22'd0, x};
    acc   = '0;
    for (int i = 0; i < 14; i++) begin
      acc = acc + 27'(x_pad[i*23 +: 23]);
    end
    fold = 24'(acc[22:0]) + 24'(acc[26:23]);
    r    = 6'(fold % 24'd47);
  end
endmodule

module x_300_mod_47_loader #(
  parameter int WORD_W = 30,
  parameter int X_W    = 300,
  parameter int R_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [R_W-1:0]    out_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  localparam int NWORDS = X_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  if (X_W % WORD_W != 0) begin : g_bad_word_w
    $error("X_W must be a multiple of WORD_W");
  end
  if (X_W != 300 || R_W != 6) begin : g_bad_core_w
    $error("core is fixed at a 300-bit operand and 6-bit residue");
  end

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [X_W-1:0]   x_reg;
  logic [5:0]       core_r;
  logic             accept;
  logic             final_word;

  x_300_mod_47 u_core (
    .x (x_reg),
    .r (core_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    final_word = 1'b0;
    case (state)
      LOAD: begin
        in_ready   = 1'b1;
        accept     = in_valid;
        // in_last and the last slot on the same word still mean a single completion
        final_word = in_last || (cnt == CNT_W'(NWORDS - 1));
        if (accept && final_word) begin
          state_nx = CALC;
        end
      end
      CALC: state_nx = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_nx = LOAD;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      x_reg     <= '0;
      out_res   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            x_reg[cnt*WORD_W +: WORD_W] <= in_data;
            cnt <= final_word ? '0 : cnt + CNT_W'(1);
          end
        end
        CALC: begin
          out_res   <= R_W'(core_r);
          out_valid <= 1'b1;
        end
        HOLD: begin
          // clearing here is what zero-fills the slots a short operand never writes
          if (out_ready) begin
            out_valid <= 1'b0;
            x_reg     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != LOAD) || (cnt != '0);
endmodule

// File: tb/tb_x_300_mod_47_loader.sv
// Bench for x_300_mod_47_loader: directed cases plus randomized operands, all checked
// cycle by cycle against a transaction-level residue model.

module tb_x_300_mod_47_loader;
  localparam int NW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [5:0]  out_res;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;
  bit check_en = 1'b0;
  bit rand_ready = 1'b0;

  x_300_mod_47_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_res   (out_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // residue of sum(q[k] * 2^(30k)) by Horner from the most significant word
  function automatic int mod47(input logic [29:0] q[$]);
    longint r = 0;
    for (int k = q.size() - 1; k >= 0; k--) r = ((r << 30) + longint'(q[k])) % 47;
    return int'(r);
  endfunction

  // model: transaction-level view of the operand being collected and the pending result
  bit          m_accepting = 1'b1;
  bit          m_calc_due = 1'b0;
  bit          m_pending = 1'b0;
  int          m_res = 0;
  logic [29:0] m_words[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_accepting = 1'b1;
      m_calc_due  = 1'b0;
      m_pending   = 1'b0;
      m_res       = 0;
      m_words.delete();
    end else if (m_pending) begin
      if (out_ready) begin
        m_pending   = 1'b0;
        m_accepting = 1'b1;
        m_words.delete();
      end
    end else if (m_calc_due) begin
      m_res      = mod47(m_words);
      m_pending  = 1'b1;
      m_calc_due = 1'b0;
    end else if (m_accepting && in_valid) begin
      m_words.push_back(in_data);
      if (in_last || m_words.size() == NW) begin
        m_accepting = 1'b0;
        m_calc_due  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && check_en) begin
      chk("in_ready", int'(in_ready), int'(m_accepting));
      chk("out_valid", int'(out_valid), int'(m_pending));
      chk("out_res", int'(out_res), m_res);
      chk("busy", int'(busy), int'(!m_accepting || m_words.size() != 0));
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = 1'($urandom);
  end

  task automatic send_op(input logic [29:0] w[NW], input int n, input bit last_fin, input bit gaps);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      bit acc = 1'b0;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 30'($urandom);
          in_last  = 1'($urandom);
          @(posedge clk); #2;
        end
      end
      in_valid = 1'b1;
      in_data  = w[k];
      in_last  = (k == n - 1) && last_fin;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #2;
        waited++;
        if (!acc && waited > 300) begin
          n_chk++;
          $display("FAIL accept_timeout: word %0d not accepted after %0d cycles, expected acceptance", k, waited);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_data  = 30'($urandom);
    in_last  = 1'($urandom);
  endtask

  // called at posedge+2 right after the final accept
  task automatic check_latency(input string nm, input int lit);
    @(negedge clk);
    chk({nm, "_valid_t1"}, int'(out_valid), 0);
    @(negedge clk);
    chk({nm, "_valid_t2"}, int'(out_valid), 1);
    chk({nm, "_res"}, int'(out_res), lit);
    @(posedge clk); #2;
  endtask

  task automatic fill(output logic [29:0] w[NW], input logic [29:0] v);
    for (int k = 0; k < NW; k++) w[k] = v;
  endtask

  initial begin
    logic [29:0] w[NW];
    logic [29:0] q[$];

    q = {30'd46};
    chk("model_pin_46", mod47(q), 46);
    q = {30'd0, 30'd1};
    chk("model_pin_2p30", mod47(q), 34);
    q = {};
    for (int k = 0; k < NW; k++) q.push_back(30'h3FFFFFFF);
    chk("model_pin_ones", mod47(q), 1);

    #13 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_res", int'(out_res), 0);
    chk("rst_busy", int'(busy), 0);
    check_en = 1'b1;

    fill(w, 30'd0);
    send_op(w, NW, 1'b0, 1'b0);
    check_latency("zeros", 0);

    fill(w, 30'h3FFFFFFF);
    send_op(w, NW, 1'b0, 1'b0);
    check_latency("ones", 1);

    fill(w, 30'd0);
    w[1] = 30'd1;
    send_op(w, 2, 1'b1, 1'b0);
    check_latency("two_pow30", 34);

    w[0] = 30'd46;
    send_op(w, 1, 1'b1, 1'b0);
    check_latency("w46", 46);
    w[0] = 30'd47;
    send_op(w, 1, 1'b1, 1'b0);
    check_latency("w47", 0);

    out_ready = 1'b0;
    w[0] = 30'd1000;
    send_op(w, 1, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 30'd7;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_res", int'(out_res), 1000 % 47);
      chk("hold_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("hold_released", int'(in_ready), 1);
    w[0] = 30'd5;
    send_op(w, 1, 1'b1, 1'b0);
    check_latency("after_hold", 5);

    fill(w, 30'h3FFFFFFF);
    send_op(w, 4, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_res", int'(out_res), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #2;
    w[0] = 30'd5;
    send_op(w, 1, 1'b1, 1'b0);
    check_latency("after_rst", 5);

    rand_ready = 1'b1;
    for (int op = 0; op < 40; op++) begin
      int n = $urandom_range(1, NW);
      for (int k = 0; k < NW; k++) w[k] = 30'($urandom);
      if (op % 5 == 0) for (int k = 0; k < NW; k++) w[k] = 30'h3FFFFFFF - 30'($urandom_range(0, 3));
      send_op(w, n, (n < NW) ? 1'b1 : 1'($urandom), 1'b1);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("drain_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
